// File: rtl/pipeline_elastic_stage.sv
// pipeline_elastic_stage
//   Elastic register slice between two pipeline stages. Holds up to two beats
//   (main + skid) of an opaque payload plus its active-list tag, with a
//   valid/ready handshake on both sides, full flush, and selective squash of
//   entries younger than a mispredicted instruction.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kill all entries and drop the incoming beat
//   in_valid/in_ready     upstream handshake (in_ready is a flop output)
//   in_data/in_tag        upstream payload and active-list index
//   out_valid/out_ready   downstream handshake (out_valid is a flop output)
//   out_data/out_tag      payload and tag of the oldest held entry
//   squash_valid/tag      kill entries younger than squash_tag
//   head_tag              active-list head, origin for age comparison
//
// Occupancy
//   state | meaning
//   EMPTY | main_valid_q=0, skid_valid_q=0
//   ONE   | main_valid_q=1, skid_valid_q=0
//   FULL  | main_valid_q=1, skid_valid_q=1 (in_ready low)
module pipeline_elastic_stage #(
   parameter int DATA_WIDTH      = 64,
   parameter int FREE_LIST_WIDTH = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_WIDTH-1:0]      in_data,
   input  logic [FREE_LIST_WIDTH-1:0] in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [FREE_LIST_WIDTH-1:0] out_tag,
   input  logic                       squash_valid,
   input  logic [FREE_LIST_WIDTH-1:0] squash_tag,
   input  logic [FREE_LIST_WIDTH-1:0] head_tag
);

   localparam int W = FREE_LIST_WIDTH;

   logic                  main_valid_q, main_valid_d;
   logic [DATA_WIDTH-1:0] main_data_q,  main_data_d;
   logic [W-1:0]          main_tag_q,   main_tag_d;
   logic                  skid_valid_q, skid_valid_d;
   logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
   logic [W-1:0]          skid_tag_q,   skid_tag_d;

   logic                  accept, pop, in_keep;
   logic                  rem0_v, rem1_v;
   logic [DATA_WIDTH-1:0] rem0_d;
   logic [W-1:0]          rem0_t;

   // Ages are measured from the active-list head so the comparison survives
   // tag wrap-around.
   function automatic logic younger(input logic [W-1:0] t,
                                    input logic [W-1:0] sq,
                                    input logic [W-1:0] head);
      logic [W-1:0] age_t;
      logic [W-1:0] age_sq;
      age_t  = t - head;
      age_sq = sq - head;
      return age_t > age_sq;
   endfunction

   always_comb begin
      accept = in_valid & ~skid_valid_q;
      pop    = main_valid_q & out_ready;

      // Entries that remain after the consumer takes its beat, oldest first.
      rem0_v = pop ? skid_valid_q : main_valid_q;
      rem0_d = pop ? skid_data_q  : main_data_q;
      rem0_t = pop ? skid_tag_q   : main_tag_q;
      rem1_v = pop ? 1'b0         : skid_valid_q;

      if (squash_valid) begin
         if (younger(rem0_t, squash_tag, head_tag))     rem0_v = 1'b0;
         if (younger(skid_tag_q, squash_tag, head_tag)) rem1_v = 1'b0;
      end
      in_keep = accept & ~(squash_valid & younger(in_tag, squash_tag, head_tag));

      // Invalid entries carry zero payload and tag.
      main_valid_d = 1'b0;
      main_data_d  = '0;
      main_tag_d   = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
      skid_tag_d   = '0;

      if (!flush) begin
         // Compact survivors: first goes to main, second to skid.
         if (rem0_v) begin
            main_valid_d = 1'b1;
            main_data_d  = rem0_d;
            main_tag_d   = rem0_t;
            if (rem1_v) begin
               skid_valid_d = 1'b1;
               skid_data_d  = skid_data_q;
               skid_tag_d   = skid_tag_q;
            end else if (in_keep) begin
               skid_valid_d = 1'b1;
               skid_data_d  = in_data;
               skid_tag_d   = in_tag;
            end
         end else if (rem1_v) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            main_tag_d   = skid_tag_q;
            if (in_keep) begin
               skid_valid_d = 1'b1;
               skid_data_d  = in_data;
               skid_tag_d   = in_tag;
            end
         end else if (in_keep) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_tag_d   = in_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_tag_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_tag_q   <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_tag_q   <= main_tag_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_tag_q   <= skid_tag_d;
      end
   end

   assign in_ready  = ~skid_valid_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign out_tag   = main_tag_q;

endmodule
